// File: rtl/dmx_framer_pkg.sv
// DMX512 framer shared package: bit-timing defaults, slot limits
// and the framer state encoding.
package dmx_framer_pkg;

  localparam int DMX_CLKS_PER_BIT = 48;
  localparam int DMX_BREAK_BITS   = 22;
  localparam int DMX_MAB_BITS     = 3;
  localparam int DMX_MTBP_BITS    = 0;
  localparam int DMX_MAX_SLOTS    = 512;
  localparam int DMX_SLOT_CELLS   = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BREAK,
    ST_MAB,
    ST_SLOT,
    ST_MTBP
  } dmx_state_e;

endpackage

// File: rtl/dmx_slot_ram.sv
// 1W1R synchronous slot RAM, 8-bit wide, read-before-write.
// Ports: clk, we/waddr/wdata write side, re/raddr/rdata read side.
module dmx_slot_ram
  import dmx_framer_pkg::*;
#(
  parameter int DEPTH = DMX_MAX_SLOTS,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmx_framer.sv
// DMX512 frame generator: BREAK, MAB, start code, SLOTS x 8N2, MTBP.
// Ports: CLK12, RESET_N, enable, wr_en/wr_addr/wr_data, commit,
// dmx_data, busy, frame_start, commit_pending.
// Option: DMX_DOUBLE_BUFFER_EN selects a two-bank slot buffer.
module dmx_framer
  import dmx_framer_pkg::*;
#(
  parameter int         CLKS_PER_BIT = DMX_CLKS_PER_BIT,
  parameter int         BREAK_BITS   = DMX_BREAK_BITS,
  parameter int         MAB_BITS     = DMX_MAB_BITS,
  parameter int         MTBP_BITS    = DMX_MTBP_BITS,
  parameter int         SLOTS        = DMX_MAX_SLOTS,
  parameter logic [7:0] START_CODE   = 8'h00
) (
  input  logic       CLK12,
  input  logic       RESET_N,
  input  logic       enable,
  input  logic       wr_en,
  input  logic [8:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       dmx_data,
  output logic       busy,
  output logic       frame_start,
  output logic       commit_pending
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int CW = 16;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  dmx_state_e    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] cell_q, cell_d;
  logic [9:0]    slot_q, slot_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          line_d, fs_d, wrap;
  logic          re;
  logic [8:0]    raddr;
  logic [7:0]    rd_byte;

  // Next state and bit/cell/slot counters
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    cell_d  = cell_q;
    slot_d  = slot_q;
    shreg_d = shreg_q;
    wrap    = (tmr_q == T_LAST);
    if (state_q != ST_IDLE) tmr_d = wrap ? '0 : tmr_q + TW'(1);
    if (wrap) cell_d = cell_q + CW'(1);
    unique case (state_q)
      ST_IDLE: begin
        tmr_d  = '0;
        cell_d = '0;
        if (enable) state_d = ST_BREAK;
      end
      ST_BREAK: begin
        if (wrap && cell_q == CW'(BREAK_BITS - 1)) begin
          state_d = ST_MAB;
          cell_d  = '0;
        end
      end
      ST_MAB: begin
        if (wrap && cell_q == CW'(MAB_BITS - 1)) begin
          state_d = ST_SLOT;
          cell_d  = '0;
          slot_d  = '0;
        end
      end
      ST_SLOT: begin
        if (wrap) begin
          // Byte lands at the end of the start bit
          if (cell_q == '0)
            shreg_d = (slot_q == '0) ? START_CODE : rd_byte;
          else
            shreg_d = shreg_q >> 1;
          if (cell_q == CW'(DMX_SLOT_CELLS - 1)) begin
            cell_d = '0;
            if (slot_q == 10'(SLOTS)) begin
              if (MTBP_BITS == 0)
                state_d = enable ? ST_BREAK : ST_IDLE;
              else
                state_d = ST_MTBP;
            end else begin
              slot_d = slot_q + 10'd1;
            end
          end
        end
      end
      ST_MTBP: begin
        if (wrap && cell_q == CW'(MTBP_BITS - 1)) begin
          state_d = enable ? ST_BREAK : ST_IDLE;
          cell_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level for the state being entered
  always_comb begin
    line_d = 1'b1;
    unique case (1'b1)
      state_d == ST_BREAK:
        line_d = 1'b0;
      state_d == ST_SLOT && cell_d == '0:
        line_d = 1'b0;
      state_d == ST_SLOT && cell_d >= CW'(1)
        && cell_d <= CW'(8):
        line_d = shreg_d[0];
      default:
        line_d = 1'b1;
    endcase
  end

  assign fs_d = (state_d == ST_BREAK) && (state_q != ST_BREAK);

  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      cell_q      <= '0;
      slot_q      <= '0;
      shreg_q     <= '0;
      dmx_data    <= 1'b1;
      busy        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      cell_q      <= cell_d;
      slot_q      <= slot_d;
      shreg_q     <= shreg_d;
      dmx_data    <= line_d;
      busy        <= (state_d != ST_IDLE);
      frame_start <= fs_d;
    end
  end

  // One read per data slot, on the first clock of its start bit
  assign re = (state_q == ST_SLOT) && (cell_q == '0)
           && (tmr_q == '0) && (slot_q != '0);
  assign raddr = 9'(slot_q - 10'd1);

`ifdef DMX_DOUBLE_BUFFER_EN
  logic bank_q;

  // Swap on BREAK entry; a commit seen on that edge waits a frame
  always_ff @(posedge CLK12 or negedge RESET_N) begin
    if (!RESET_N) begin
      bank_q         <= 1'b0;
      commit_pending <= 1'b0;
    end else if (fs_d) begin
      bank_q         <= bank_q ^ commit_pending;
      commit_pending <= commit;
    end else if (commit) begin
      commit_pending <= 1'b1;
    end
  end

  dmx_slot_ram #(.DEPTH(2 * DMX_MAX_SLOTS)) u_ram (
    .clk   (CLK12),
    .we    (wr_en),
    .waddr ({~bank_q, wr_addr}),
    .wdata (wr_data),
    .re    (re),
    .raddr ({bank_q, raddr}),
    .rdata (rd_byte)
  );
`else
  logic unused_commit;
  assign unused_commit  = commit;
  assign commit_pending = 1'b0;

  dmx_slot_ram #(.DEPTH(DMX_MAX_SLOTS)) u_ram (
    .clk   (CLK12),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (re),
    .raddr (raddr),
    .rdata (rd_byte)
  );
`endif

endmodule

// File: doc/dmx_framer.md
# dmx_framer

DMX512 frame generator that drives the `data` input of `dmx_modulator`, replacing the fixed 250 kbaud toggle source. It holds a 512-byte slot buffer written by the host side and sends continuous DMX512 frames at 250 kbaud from a 12 MHz clock. Each frame is BREAK, then MAB, then the start code, then `SLOTS` data slots, then MTBP; every slot is 8N2, LSB first.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 48: clocks per bit (12 MHz / 250 kbaud).
- `BREAK_BITS`, default 22: BREAK length in bit times (88 µs).
- `MAB_BITS`, default 3: mark-after-break length in bit times (12 µs).
- `MTBP_BITS`, default 0: idle mark after the last slot, in bit times.
- `SLOTS`, default 512: data slots per frame. Legal range 1..512.
- `START_CODE`, default 8'h00: slot-0 byte.

Ports (one clock; reset is asynchronous and active-low):
- `CLK12` in 1: system clock, 12 MHz.
- `RESET_N` in 1: asynchronous, active-low reset.
- `enable` in 1: start and continue frames while high.
- `wr_en` in 1: slot-buffer write strobe.
- `wr_addr` in 9: slot index 0..511 (slot 1 = address 0).
- `wr_data` in 8: slot value.
- `commit` in 1: request a bank swap. Used only with double buffering.
- `dmx_data` out 1: serial line, 1 = mark/idle. Connects to `dmx_modulator.data`.
- `busy` out 1: high from BREAK entry to end of MTBP.
- `frame_start` out 1: one-cycle pulse on the cycle BREAK is entered.
- `commit_pending` out 1: a swap has been requested but not yet applied.

## Operation
- States: IDLE → BREAK → MAB → SLOT → MTBP → (BREAK if `enable`, else IDLE).
- **IDLE**
  - `dmx_data`=1.
  - Leaves IDLE on the first cycle `enable`=1.
- **BREAK:** `dmx_data`=0 for `BREAK_BITS*CLKS_PER_BIT` clocks.
- **MAB:** `dmx_data`=1 for `MAB_BITS*CLKS_PER_BIT` clocks.
- **SLOT**
  - Slot counter k runs 0..`SLOTS`. k=0 sends `START_CODE`; k≥1 sends buffer[k-1].
  - Each slot is 11 bit cells: start (0), d0..d7, stop, stop (1).
  - Each bit cell lasts exactly `CLKS_PER_BIT` clocks.
- **MTBP:** `dmx_data`=1 for `MTBP_BITS*CLKS_PER_BIT` clocks. With `MTBP_BITS`=0 the state lasts 0 cycles.
- **`enable` deasserted mid-frame:** the current frame completes, then the block enters IDLE.
- **Bit timer:** counts 0..`CLKS_PER_BIT`-1 and wraps; the bit cell advances on the wrap.
- **Slot buffer**
  - 512×8, synchronous write, 1-cycle synchronous read.
  - Read address buffer[k-1] is issued on the first cycle of slot k's start bit. The byte is loaded into the shift register before d0.
  - Write and read to the same address in the same cycle: the read returns the old data.
  - Writes to addresses ≥ `SLOTS` are stored but never sent.
- **Reset**
  - All state is cleared immediately, including mid-frame: IDLE, `dmx_data`=1, `busy`=0, `frame_start`=0, `commit_pending`=0, counters 0.
  - Buffer contents are undefined after reset.

## Timing
- `frame_start` and `busy` rise on the clock after `enable` is sampled high in IDLE. `dmx_data` falls on that same edge.
- Frame length is `(BREAK_BITS+MAB_BITS+11*(SLOTS+1)+MTBP_BITS)*CLKS_PER_BIT` clocks. At defaults this is 272064 clocks.
- Back-to-back frames: the next BREAK begins on the cycle after the last MTBP cycle, or after the last stop bit when `MTBP_BITS`=0.
- `busy` falls on the same edge that IDLE is entered.
- `dmx_data` is registered, with no combinational path from any input.

## Configuration
- Macro: `DMX_DOUBLE_BUFFER_EN`.
- **Defined:**
  - The buffer has two banks. Writes always go to the shadow bank; frames read the active bank.
  - A `commit` pulse sets `commit_pending`.
  - On the next BREAK entry, the banks swap and `commit_pending` clears in the same cycle.
  - A `commit` that arrives on the BREAK-entry cycle itself applies to the following frame.
  - After the swap, the new shadow bank holds stale data; the host rewrites all slots.
- **Undefined:**
  - Single bank; writes are visible to any slot not yet read.
  - `commit` is ignored and `commit_pending` is tied to 0.

## Structure
- Shared package holds:
  - DMX constants: default baud divider, default BREAK, MAB and MTBP bit counts, maximum slot count of 512.
  - Framer state enum.
- One sub-module: `dmx_slot_ram`, a parameterised 1W1R synchronous RAM with depth 512 (1024 when double buffering is enabled) and 8-bit width. It is inferable as iCE40 block RAM.

## Test plan
- **Default frame:** reset; write buffer[0]=8'hA5 and buffer[1]=8'h3C; set `enable`=1.
  - `dmx_data` low for 1056 clocks, high for 144 clocks.
  - Then bits 0,00000000,11 at 48 clocks each, then 0,10100101,11, then 0,00111100,11.
- **Short frame, repeat:** `SLOTS`=2, `MTBP_BITS`=4, `enable` held high.
  - Period between `frame_start` pulses is exactly (22+3+33+4)*48 = 2976 clocks.
- **Enable drop:** drop `enable` during slot 1 → the frame completes, `busy` falls, and `dmx_data` stays 1 with no further `frame_start`.
- **Reset mid-frame:** assert `RESET_N` low during BREAK → `dmx_data`=1 and `busy`=0 asynchronously. After release with `enable`=1, a full 1056-clock BREAK follows.
- **Double buffer (`DMX_DOUBLE_BUFFER_EN`):** write 8'h11 to slot 0, pulse `commit`, then write 8'h22 during the frame.
  - The next frame sends 8'h11 in slot 1.
  - `commit_pending` clears at that frame's BREAK.
  - 8'h22 appears only after a second `commit`.
- **Write/read collision (macro undefined):** write buffer[0] on the exact read cycle → the old byte is sent this frame and the new byte next frame.
